// File: rtl/silife_gen_controller.sv
`default_nettype none
// ============================================================================
// Module   : silife_gen_controller
// Purpose  : Command sequencer for a SiLife cell grid. Accepts host commands
//            (run, pause, N-step, clear, revive, period set, gen reset),
//            paces generations with a prescaler and drives the grid's shared
//            enable / reset / revive strobes.
// Revision : 1.0 - initial release
// ============================================================================
module silife_gen_controller #(
    parameter int ROW_BITS       = 3,
    parameter int COL_BITS       = 3,
    parameter int PERIOD_BITS    = 16,
    parameter int GEN_BITS       = 16,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [15:0]         cmd_arg,
    output logic                cell_enable,
    output logic                cell_reset,
    output logic                cell_revive,
    output logic [ROW_BITS-1:0] revive_row,
    output logic [COL_BITS-1:0] revive_col,
    output logic                running,
    output logic                step_done,
    output logic [GEN_BITS-1:0] gen_count
);

    localparam logic [2:0] OP_STEP       = 3'd1;
    localparam logic [2:0] OP_RUN        = 3'd2;
    localparam logic [2:0] OP_PAUSE      = 3'd3;
    localparam logic [2:0] OP_CLEAR      = 3'd4;
    localparam logic [2:0] OP_REVIVE     = 3'd5;
    localparam logic [2:0] OP_SET_PERIOD = 3'd6;
    localparam logic [2:0] OP_GEN_RESET  = 3'd7;

    localparam logic [PERIOD_BITS-1:0] PERIOD_ONE   = PERIOD_BITS'(1);
    // A zero period would never let the prescaler terminate; clamp it to 1.
    localparam logic [PERIOD_BITS-1:0] RESET_PERIOD =
        (DEFAULT_PERIOD == 0) ? PERIOD_ONE : PERIOD_BITS'(DEFAULT_PERIOD);

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [PERIOD_BITS-1:0] prescaler_q;
    logic [PERIOD_BITS-1:0] period_q;
    logic [15:0]            steps_left_q;
    logic [GEN_BITS-1:0]    gen_count_q;
    logic                   cmd_ready_q;
    logic                   cell_enable_q;
    logic                   cell_reset_q;
    logic                   cell_revive_q;
    logic [ROW_BITS-1:0]    revive_row_q;
    logic [COL_BITS-1:0]    revive_col_q;
    logic                   running_q;
    logic                   step_done_q;

    logic                   cmd_fire;
    logic                   active;
    logic                   due;
    logic                   revive_cmd;
    logic                   gen_reset_cmd;
    logic [PERIOD_BITS-1:0] arg_period;
    logic [15:0]            arg_steps;

    // Decode the accepted command and whether a generation is due this cycle.
    always_comb begin
        cmd_fire      = cmd_valid && cmd_ready_q;
        active        = (state_q == ST_RUN) || (state_q == ST_STEP);
        due           = active && (prescaler_q >= (period_q - PERIOD_ONE));
        revive_cmd    = cmd_fire && (cmd_op == OP_REVIVE);
        gen_reset_cmd = cmd_fire && (cmd_op == OP_GEN_RESET);
        arg_period    = PERIOD_BITS'(cmd_arg);
        if (arg_period == '0) begin
            arg_period = PERIOD_ONE;
        end
        arg_steps     = (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
    end

    // Controller state machine, prescaler, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_PAUSED;
            prescaler_q   <= '0;
            period_q      <= RESET_PERIOD;
            steps_left_q  <= '0;
            gen_count_q   <= '0;
            cmd_ready_q   <= 1'b1;
            cell_enable_q <= 1'b0;
            cell_reset_q  <= 1'b0;
            cell_revive_q <= 1'b0;
            revive_row_q  <= '0;
            revive_col_q  <= '0;
            running_q     <= 1'b0;
            step_done_q   <= 1'b0;
        end else begin
            cell_enable_q <= 1'b0;
            cell_reset_q  <= 1'b0;
            cell_revive_q <= 1'b0;
            step_done_q   <= 1'b0;
            cmd_ready_q   <= 1'b1;

            if (state_q == ST_CLEAR) begin
                // The clear strobe has been issued; settle back to idle.
                state_q   <= ST_PAUSED;
                running_q <= 1'b0;
            end else if (cmd_fire && (cmd_op == OP_STEP)) begin
                // Start or restart an N-step sequence from a fresh interval.
                state_q      <= ST_STEP;
                steps_left_q <= arg_steps;
                prescaler_q  <= '0;
                running_q    <= 1'b1;
            end else if (cmd_fire && (cmd_op == OP_RUN)) begin
                state_q      <= ST_RUN;
                steps_left_q <= '0;
                prescaler_q  <= '0;
                running_q    <= 1'b1;
            end else if (cmd_fire && (cmd_op == OP_PAUSE)) begin
                state_q      <= ST_PAUSED;
                steps_left_q <= '0;
                prescaler_q  <= '0;
                running_q    <= 1'b0;
            end else if (cmd_fire && (cmd_op == OP_CLEAR)) begin
                state_q      <= ST_CLEAR;
                cell_reset_q <= 1'b1;
                gen_count_q  <= '0;
                steps_left_q <= '0;
                prescaler_q  <= '0;
                cmd_ready_q  <= 1'b0;
                running_q    <= 1'b0;
            end else begin
                // NOP, REVIVE, SET_PERIOD, GEN_RESET or idle: pacing continues.
                if (revive_cmd) begin
                    cell_revive_q <= 1'b1;
                    revive_row_q  <= cmd_arg[COL_BITS +: ROW_BITS];
                    revive_col_q  <= cmd_arg[COL_BITS-1:0];
                end
                if (cmd_fire && (cmd_op == OP_SET_PERIOD)) begin
                    period_q <= arg_period;
                end

                if (due && !revive_cmd) begin
                    cell_enable_q <= 1'b1;
                    prescaler_q   <= '0;
                    gen_count_q   <= gen_reset_cmd ? '0 : gen_count_q + GEN_BITS'(1);
                    if (state_q == ST_STEP) begin
                        steps_left_q <= steps_left_q - 16'd1;
                        if (steps_left_q == 16'd1) begin
                            state_q     <= ST_PAUSED;
                            step_done_q <= 1'b1;
                            running_q   <= 1'b0;
                        end
                    end
                end else begin
                    // A revive colliding with a due enable holds the prescaler
                    // at its terminal value so the enable fires next cycle.
                    if (active && !due) begin
                        prescaler_q <= prescaler_q + PERIOD_ONE;
                    end
                    if (gen_reset_cmd) begin
                        gen_count_q <= '0;
                    end
                end
            end
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cell_enable = cell_enable_q;
    assign cell_reset  = cell_reset_q;
    assign cell_revive = cell_revive_q;
    assign revive_row  = revive_row_q;
    assign revive_col  = revive_col_q;
    assign running     = running_q;
    assign step_done   = step_done_q;
    assign gen_count   = gen_count_q;

endmodule
`default_nettype wire

// File: tb/tb_silife_gen_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_silife_gen_controller
// Purpose  : Directed self-checking bench for silife_gen_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_silife_gen_controller;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cell_enable;
    logic        cell_reset;
    logic        cell_revive;
    logic [2:0]  revive_row;
    logic [2:0]  revive_col;
    logic        running;
    logic        step_done;
    logic [15:0] gen_count;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_STEP      = 3'd1;
    localparam logic [2:0] OP_RUN       = 3'd2;
    localparam logic [2:0] OP_PAUSE     = 3'd3;
    localparam logic [2:0] OP_CLEAR     = 3'd4;
    localparam logic [2:0] OP_REVIVE    = 3'd5;
    localparam logic [2:0] OP_SETPER    = 3'd6;
    localparam logic [2:0] OP_GENRST    = 3'd7;

    silife_gen_controller #(
        .ROW_BITS       (3),
        .COL_BITS       (3),
        .PERIOD_BITS    (16),
        .GEN_BITS       (16),
        .DEFAULT_PERIOD (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cell_enable (cell_enable),
        .cell_reset  (cell_reset),
        .cell_revive (cell_revive),
        .revive_row  (revive_row),
        .revive_col  (revive_col),
        .running     (running),
        .step_done   (step_done),
        .gen_count   (gen_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command at a falling edge, let it be accepted at the next
    // rising edge, then return at the falling edge after acceptance.
    task automatic issue(input logic [2:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 16'd0;
        @(negedge clk);
    endtask

    // Wait (bounded) for step_done, sampled on falling edges.
    task automatic wait_done(input int bound, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (step_done) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic [19:0] en_mask;
        int          n_en;
        int          n_done;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready",   {31'd0, cmd_ready},   32'd1);
        chk("rst_running", {31'd0, running},     32'd0);
        chk("rst_enable",  {31'd0, cell_enable}, 32'd0);
        chk("rst_done",    {31'd0, step_done},   32'd0);
        chk("rst_creset",  {31'd0, cell_reset},  32'd0);
        chk("rst_revive",  {31'd0, cell_revive}, 32'd0);
        chk("rst_gen",     {16'd0, gen_count},   32'd0);

        // STEP 3 at period 1: enables after edges N+1..N+3, done with the 3rd
        issue(OP_STEP, 16'd3);
        chk("s3_running", {31'd0, running}, 32'd1);
        chk("s3_en0",     {31'd0, cell_enable}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("s3_en%0d", i),   {31'd0, cell_enable}, (i <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("s3_done%0d", i), {31'd0, step_done},   (i == 3) ? 32'd1 : 32'd0);
        end
        chk("s3_gen",     {16'd0, gen_count}, 32'd3);
        chk("s3_idle",    {31'd0, running},   32'd0);

        // Period 4 RUN: pulses at acceptance+4, +8, ... (5 in 20 cycles)
        issue(OP_GENRST, 16'd0);
        chk("gr_gen", {16'd0, gen_count}, 32'd0);
        issue(OP_SETPER, 16'd4);
        issue(OP_RUN, 16'd0);
        en_mask = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            en_mask[i-1] = cell_enable;
        end
        chk("p4_mask",    {12'd0, en_mask}, 32'h0008_8888);
        chk("p4_gen",     {16'd0, gen_count}, 32'd5);
        chk("p4_running", {31'd0, running}, 32'd1);

        // Period 2 RUN, then PAUSE mid-interval
        issue(OP_PAUSE, 16'd0);
        issue(OP_SETPER, 16'd2);
        issue(OP_RUN, 16'd0);
        @(negedge clk);
        chk("p2_en1", {31'd0, cell_enable}, 32'd0);
        @(negedge clk);
        chk("p2_en2", {31'd0, cell_enable}, 32'd1);
        issue(OP_PAUSE, 16'd0);
        n_en   = 0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cell_enable) n_en++;
            if (step_done)   n_done++;
        end
        chk("pz_enables", n_en,   32'd0);
        chk("pz_done",    n_done, 32'd0);
        chk("pz_gen",     {16'd0, gen_count}, 32'd6);
        chk("pz_running", {31'd0, running}, 32'd0);

        // Period 1 RUN with REVIVE colliding with a due enable
        issue(OP_SETPER, 16'd1);
        issue(OP_RUN, 16'd0);
        issue(OP_REVIVE, 16'h002B);
        chk("rv_strobe", {31'd0, cell_revive}, 32'd1);
        chk("rv_row",    {29'd0, revive_row},  32'd5);
        chk("rv_col",    {29'd0, revive_col},  32'd3);
        chk("rv_en",     {31'd0, cell_enable}, 32'd0);
        chk("rv_gen",    {16'd0, gen_count},   32'd6);
        @(negedge clk);
        chk("rv_strobe_off", {31'd0, cell_revive}, 32'd0);
        chk("rv_en_next",    {31'd0, cell_enable}, 32'd1);
        chk("rv_gen_next",   {16'd0, gen_count},   32'd7);
        // GEN_RESET coinciding with an enable leaves gen_count at 0
        issue(OP_GENRST, 16'd0);
        chk("grc_en",  {31'd0, cell_enable}, 32'd1);
        chk("grc_gen", {16'd0, gen_count},   32'd0);

        // Seven generations, then CLEAR with a STEP held behind it
        issue(OP_PAUSE, 16'd0);
        issue(OP_GENRST, 16'd0);
        issue(OP_STEP, 16'd7);
        wait_done(20, "s7_timeout");
        chk("s7_gen", {16'd0, gen_count}, 32'd7);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        cmd_arg   = 16'd0;
        @(posedge clk);
        #1;
        cmd_op    = OP_STEP;
        cmd_arg   = 16'd2;
        @(negedge clk);
        chk("cl_creset",  {31'd0, cell_reset},  32'd1);
        chk("cl_ready",   {31'd0, cmd_ready},   32'd0);
        chk("cl_gen",     {16'd0, gen_count},   32'd0);
        chk("cl_en",      {31'd0, cell_enable}, 32'd0);
        chk("cl_running", {31'd0, running},     32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("cl_creset_off", {31'd0, cell_reset}, 32'd1 - 32'd1);
        chk("cl_ready_back", {31'd0, cmd_ready},  32'd1);
        chk("cl_paused",     {31'd0, running},    32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 16'd0;
        @(negedge clk);
        chk("held_step_run", {31'd0, running}, 32'd1);
        wait_done(10, "held_timeout");
        chk("held_gen", {16'd0, gen_count}, 32'd2);

        // Counter wrap: 0xFFFF generations, then STEP 2 goes 0x0000, 0x0001
        issue(OP_GENRST, 16'd0);
        issue(OP_STEP, 16'hFFFF);
        wait_done(70000, "big_timeout");
        chk("big_gen", {16'd0, gen_count}, 32'h0000_FFFF);
        issue(OP_STEP, 16'd2);
        @(negedge clk);
        chk("wrap_gen0", {16'd0, gen_count}, 32'h0000_0000);
        @(negedge clk);
        chk("wrap_gen1", {16'd0, gen_count}, 32'h0000_0001);
        chk("wrap_done", {31'd0, step_done}, 32'd1);

        // STEP 0 behaves as STEP 1
        issue(OP_STEP, 16'd0);
        n_en = 0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (cell_enable) n_en++;
            chk($sformatf("s0_done%0d", i), {31'd0, step_done}, (i == 1) ? 32'd1 : 32'd0);
        end
        chk("s0_enables", n_en, 32'd1);
        chk("s0_gen",     {16'd0, gen_count}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
